instr_fetch: RTL and testbench

Fetch stage directly downstream of the 6-bit program counter. Holds the 64x16 instruction memory and the instruction register (IR). Each enabled cycle the IR captures the word at the address presented by the PC. Also provides a handshaked program-load port so a host can write user code into memory while execution is frozen.

---
 rtl/instr_fetch.sv | 143 ++++++++++++++
 tb/tb_instr_fetch.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage holding the 64x16 instruction memory and the
// instruction register. A handshaked load port lets a host write user code
// while execution is frozen. An IDLE/LOADING/FLUSH FSM sequences load sessions.
// Optional feature macro: WRITE_PROTECT_EN (blocks writes to the BIOS region
// and raises a sticky protect_err flag).
module instr_fetch #(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned BIOS_WORDS = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              load_start,
    input  logic              load_end,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] instr_reg,
    output logic              instr_valid,
    output logic              busy,
    output logic              protect_err
);

    localparam int unsigned       DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] BIOS_LIMIT = ADDR_W'(BIOS_WORDS);
`ifdef WRITE_PROTECT_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOADING = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic                valid_q, valid_d;
    logic                beat_acc;
    logic                in_bios;
    logic                wr_en;

    assign load_ready  = (state_q == S_LOADING);
    assign busy        = (state_q == S_LOADING) || (state_q == S_FLUSH);
    assign instr_reg   = ir_q;
    assign instr_valid = valid_q;

    assign beat_acc = load_valid && load_ready;
    assign in_bios  = (load_addr < BIOS_LIMIT);
    // With protection off the BIOS test folds away and every address is writable.
    assign wr_en    = beat_acc && !(WP_ON && in_bios);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start/end pulses outside their valid states are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (load_start) state_d = S_LOADING;
            S_LOADING: if (load_end)   state_d = S_FLUSH;
            S_FLUSH:                   state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    // Instruction memory: cleared on reset, written by accepted load beats.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Fetch control: IR follows the PC in IDLE when running, always in FLUSH,
    // and holds in LOADING; entering LOADING invalidates the IR.
    always_comb begin
        ir_d    = ir_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    valid_d = 1'b0;
                end else if (run) begin
                    ir_d    = mem_q[pc_addr];
                    valid_d = 1'b1;
                end
            end
            S_FLUSH: begin
                ir_d    = mem_q[pc_addr];
                valid_d = 1'b1;
            end
            default: begin
                ir_d    = ir_q;
                valid_d = valid_q;
            end
        endcase
    end

    // Instruction register and its valid flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ir_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            valid_q <= valid_d;
        end
    end

`ifdef WRITE_PROTECT_EN
    logic perr_q;

    // Sticky protection-violation flag, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perr_q <= 1'b0;
        end else if (beat_acc && in_bios) begin
            perr_q <= 1'b1;
        end
    end

    assign protect_err = perr_q;
`else
    assign protect_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: reset, load sessions, freeze,
// edge cases, reset mid-load and BIOS write behaviour.
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        run;
    logic [5:0]  pc_addr;
    logic        load_start;
    logic        load_end;
    logic        load_valid;
    logic        load_ready;
    logic [5:0]  load_addr;
    logic [15:0] load_data;
    logic [15:0] instr_reg;
    logic        instr_valid;
    logic        busy;
    logic        protect_err;

    int checks = 0;
    int errors = 0;

`ifdef WRITE_PROTECT_EN
    localparam logic [15:0] EXP_MEM5 = 16'h0000;
    localparam logic        EXP_PERR = 1'b1;
`else
    localparam logic [15:0] EXP_MEM5 = 16'h1234;
    localparam logic        EXP_PERR = 1'b0;
`endif

    instr_fetch #(.ADDR_W(6), .DATA_W(16), .BIOS_WORDS(32)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .run         (run),
        .pc_addr     (pc_addr),
        .load_start  (load_start),
        .load_end    (load_end),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .instr_reg   (instr_reg),
        .instr_valid (instr_valid),
        .busy        (busy),
        .protect_err (protect_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; run = 1'b0; pc_addr = 6'd32;
        load_start = 1'b0; load_end = 1'b0; load_valid = 1'b0;
        load_addr = '0; load_data = '0;
        #3;
        chk("rst_ir",    instr_reg, 16'h0000);
        chk("rst_valid", {15'd0, instr_valid}, 16'd0);
        chk("rst_ready", {15'd0, load_ready}, 16'd0);
        chk("rst_busy",  {15'd0, busy}, 16'd0);
        chk("rst_perr",  {15'd0, protect_err}, 16'd0);
        step(); step();
        reset_n = 1'b1;
        step();
        chk("pre_fetch_valid", {15'd0, instr_valid}, 16'd0);

        // Reset-then-fetch
        run = 1'b1; pc_addr = 6'd32;
        step();
        chk("fetch0_ir",    instr_reg, 16'h0000);
        chk("fetch0_valid", {15'd0, instr_valid}, 16'd1);

        // Load session with run forced high
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("load_busy",  {15'd0, busy}, 16'd1);
        chk("load_ready", {15'd0, load_ready}, 16'd1);
        chk("load_valid_clr", {15'd0, instr_valid}, 16'd0);
        load_valid = 1'b1; load_addr = 6'd32; load_data = 16'h1A05;
        step();
        load_addr = 6'd33; load_data = 16'h2B06;
        step();
        load_addr = 6'd63; load_data = 16'hFFFF;
        step();
        chk("load_ir_hold", instr_reg, 16'h0000);
        chk("load_valid_hold", {15'd0, instr_valid}, 16'd0);
        load_valid = 1'b0; load_end = 1'b1;
        step();
        load_end = 1'b0;
        chk("flush_busy",  {15'd0, busy}, 16'd1);
        chk("flush_ready", {15'd0, load_ready}, 16'd0);
        pc_addr = 6'd32;
        step();
        chk("flush_ir",    instr_reg, 16'h1A05);
        chk("flush_valid", {15'd0, instr_valid}, 16'd1);
        chk("idle_busy",   {15'd0, busy}, 16'd0);
        pc_addr = 6'd33;
        step();
        chk("fetch33", instr_reg, 16'h2B06);
        pc_addr = 6'd63;
        step();
        chk("fetch63", instr_reg, 16'hFFFF);

        // Freeze in IDLE
        run = 1'b0; pc_addr = 6'd32;
        step();
        chk("freeze_a", instr_reg, 16'hFFFF);
        pc_addr = 6'd33;
        step();
        chk("freeze_b", instr_reg, 16'hFFFF);

        // Second session: repeated load_start, BIOS beat, load_end with beat
        load_start = 1'b1;
        step();
        chk("s2_busy", {15'd0, busy}, 16'd1);
        step();
        load_start = 1'b0;
        chk("s2_restart_ignored", {15'd0, load_ready}, 16'd1);
        load_valid = 1'b1; load_addr = 6'd5; load_data = 16'h1234;
        step();
        chk("s2_perr_after_bios", {15'd0, protect_err}, {15'd0, EXP_PERR});
        load_addr = 6'd40; load_data = 16'h0C0C; load_end = 1'b1;
        step();
        load_valid = 1'b0; load_end = 1'b0;
        chk("s2_flush_ready", {15'd0, load_ready}, 16'd0);
        chk("s2_flush_busy",  {15'd0, busy}, 16'd1);
        chk("s2_perr_sticky", {15'd0, protect_err}, {15'd0, EXP_PERR});
        pc_addr = 6'd40;
        step();
        chk("s2_flush_ir", instr_reg, 16'h0C0C);
        chk("s2_idle_busy", {15'd0, busy}, 16'd0);

        // Beat in IDLE is not accepted; load_end in IDLE is ignored
        load_valid = 1'b1; load_addr = 6'd33; load_data = 16'hDEAD; load_end = 1'b1;
        #1;
        chk("idle_ready", {15'd0, load_ready}, 16'd0);
        step();
        load_valid = 1'b0; load_end = 1'b0;
        chk("idle_end_ignored", {15'd0, busy}, 16'd0);
        run = 1'b1; pc_addr = 6'd33;
        step();
        chk("idle_beat_nowrite", instr_reg, 16'h2B06);
        pc_addr = 6'd5;
        step();
        chk("bios_word", instr_reg, EXP_MEM5);
        chk("bios_perr", {15'd0, protect_err}, {15'd0, EXP_PERR});

        // Reset mid-load
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_valid = 1'b1; load_addr = 6'd32; load_data = 16'hAAAA;
        step();
        load_addr = 6'd34; load_data = 16'hBBBB;
        step();
        load_valid = 1'b0;
        reset_n = 1'b0;
        #2;
        chk("mid_rst_busy",  {15'd0, busy}, 16'd0);
        chk("mid_rst_ready", {15'd0, load_ready}, 16'd0);
        chk("mid_rst_ir",    instr_reg, 16'h0000);
        chk("mid_rst_perr",  {15'd0, protect_err}, 16'd0);
        step();
        reset_n = 1'b1;
        pc_addr = 6'd32; run = 1'b1;
        step();
        chk("mid_rst_mem32", instr_reg, 16'h0000);
        chk("mid_rst_valid", {15'd0, instr_valid}, 16'd1);
        pc_addr = 6'd63;
        step();
        chk("mid_rst_mem63", instr_reg, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
